// File: rtl/dma_pkg.sv
// Shared DMA types: AXI request/response structs, read-streamer state enum
// and address/byte-count typedefs.
package dma_pkg;

    localparam int AXI_ADDR_W       = 32;
    localparam int AXI_DATA_BYTES   = 64;
    localparam int AXI_4KB_BOUNDARY = 4096;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [31:0]           dma_bytes_t;

    typedef struct packed {
        axi_addr_t                 addr;
        logic [7:0]                alen;
        logic [2:0]                size;
        logic [AXI_DATA_BYTES-1:0] strb;
        logic                      valid;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DONE
    } dma_rd_strm_st_t;

endpackage

// File: rtl/dma_rd_streamer_if.sv
// Read-request channel between the read streamer and the DMA AXI port.
interface dma_rd_streamer_if;
    import dma_pkg::*;

    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/dma_burst_calc.sv
// Combinational splitter: next AXI request (alen/size/strb/bytes) for a
// given current address and remaining byte count.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BYTES_WIDTH     = 32,
    parameter int DATA_BYTES      = 64,
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic [ADDR_WIDTH-1:0]  cur_addr,
    input  logic [BYTES_WIDTH-1:0] rem,
    output logic [7:0]             alen,
    output logic [2:0]             size,
    output logic [DATA_BYTES-1:0]  strb,
    output logic [BYTES_WIDTH-1:0] req_bytes
);

    localparam int LOG = $clog2(DATA_BYTES);

    logic [ADDR_WIDTH-1:0]  off;
    logic [BYTES_WIDTH-1:0] rem_beats;
    logic [12:0]            page_beats;
    logic [8:0]             beats;
    logic [2:0]             nsize;
    logic [DATA_BYTES-1:0]  nstrb;
    logic                   burst_ok;
    int                     off_i;
    int                     nbytes;

    always_comb begin
        off        = cur_addr & ADDR_WIDTH'(DATA_BYTES - 1);
        burst_ok   = (off == '0) && (rem >= BYTES_WIDTH'(DATA_BYTES));
        rem_beats  = rem >> LOG;
        page_beats = (13'(AXI_4KB_BOUNDARY) - {1'b0, cur_addr[11:0]}) >> LOG;

        // Beats limited by remaining data, burst cap and distance to the 4 KB page end
        beats = 9'(MAX_BURST_BEATS);
        if (rem_beats < BYTES_WIDTH'(MAX_BURST_BEATS)) beats = 9'(rem_beats);
        if (page_beats < 13'(beats)) beats = 9'(page_beats);

        // Alignment and fit are both monotone in s, so the last hit is the largest
        nsize = '0;
        for (int s = 0; s <= LOG; s++) begin
            if (((cur_addr & ADDR_WIDTH'((1 << s) - 1)) == '0) &&
                (BYTES_WIDTH'(1 << s) <= rem))
                nsize = 3'(s);
        end

        off_i  = int'(off);
        nbytes = 1 << nsize;
        nstrb  = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            nstrb[i] = (i >= off_i) && (i < off_i + nbytes);

        if (burst_ok) begin
            alen      = 8'(beats - 9'd1);
            size      = 3'(LOG);
            strb      = '1;
            req_bytes = BYTES_WIDTH'(beats) << LOG;
        end else begin
            alen      = '0;
            size      = nsize;
            strb      = nstrb;
            req_bytes = BYTES_WIDTH'(1) << nsize;
        end
    end

endmodule

// File: rtl/dma_rd_streamer.sv
// DMA read streamer: turns one (address, byte count) descriptor into a
// sequence of AXI read requests split at 4 KB, burst limit and misalignment.
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BYTES_WIDTH     = 32,
    parameter int DATA_BYTES      = 64,
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  src_addr_i,
    input  logic [BYTES_WIDTH-1:0] num_bytes_i,
    input  logic                   dma_active_i,
    input  logic                   clear_dma_i,
    dma_rd_streamer_if.master      dma_axi_rd,
    output logic                   busy_o,
    output logic                   done_o
);

    dma_rd_strm_st_t        state;
    s_dma_axi_req_t         req_q;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [BYTES_WIDTH-1:0] rem;
    logic [BYTES_WIDTH-1:0] req_bytes_q;

    logic [7:0]             calc_alen;
    logic [2:0]             calc_size;
    logic [DATA_BYTES-1:0]  calc_strb;
    logic [BYTES_WIDTH-1:0] calc_bytes;

    dma_burst_calc #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .BYTES_WIDTH     (BYTES_WIDTH),
        .DATA_BYTES      (DATA_BYTES),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_calc (
        .cur_addr  (cur_addr),
        .rem       (rem),
        .alen      (calc_alen),
        .size      (calc_size),
        .strb      (calc_strb),
        .req_bytes (calc_bytes)
    );

    assign dma_axi_rd.req = req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            req_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // Abort beats everything, including a handshake in the same cycle
            if (clear_dma_i || !dma_active_i) begin
                state       <= ST_IDLE;
                req_q.valid <= 1'b0;
                busy_o      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            cur_addr <= src_addr_i;
                            rem      <= num_bytes_i;
                            busy_o   <= 1'b1;
                            if (num_bytes_i == '0) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        req_q.addr  <= cur_addr;
                        req_q.alen  <= calc_alen;
                        req_q.size  <= calc_size;
                        req_q.strb  <= calc_strb;
                        req_q.valid <= 1'b1;
                        req_bytes_q <= calc_bytes;
                        state       <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (dma_axi_rd.resp.ready) begin
                            req_q.valid <= 1'b0;
                            cur_addr    <= cur_addr + ADDR_WIDTH'(req_bytes_q);
                            rem         <= rem - req_bytes_q;
                            if (rem == req_bytes_q) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_CALC;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Directed bench for dma_rd_streamer: main instance plus a MAX_BURST_BEATS=4 instance.
module tb_dma_rd_streamer;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] num_bytes = '0;
    logic        dma_active = 1'b1;
    logic        clear_dma = 1'b0;
    logic        busy_o, done_o, busy4, done4;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [2:0]  size;
        logic [63:0] strb;
    } hs_t;
    hs_t hs_q[$];
    hs_t hs4_q[$];

    dma_rd_streamer_if bus ();
    dma_rd_streamer_if bus4 ();

    dma_rd_streamer dut (
        .clk(clk), .rst(rst), .start_i(start), .src_addr_i(src_addr),
        .num_bytes_i(num_bytes), .dma_active_i(dma_active), .clear_dma_i(clear_dma),
        .dma_axi_rd(bus), .busy_o(busy_o), .done_o(done_o)
    );

    dma_rd_streamer #(.MAX_BURST_BEATS(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start), .src_addr_i(src_addr),
        .num_bytes_i(num_bytes), .dma_active_i(dma_active), .clear_dma_i(clear_dma),
        .dma_axi_rd(bus4), .busy_o(busy4), .done_o(done4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        hs_t e;
        if (bus.req.valid && bus.resp.ready) begin
            e.addr = bus.req.addr; e.alen = bus.req.alen;
            e.size = bus.req.size; e.strb = bus.req.strb;
            hs_q.push_back(e);
        end
        if (bus4.req.valid && bus4.resp.ready) begin
            e.addr = bus4.req.addr; e.alen = bus4.req.alen;
            e.size = bus4.req.size; e.strb = bus4.req.strb;
            hs4_q.push_back(e);
        end
        if (done_o) done_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] n);
        step();
        start = 1'b1; src_addr = a; num_bytes = n;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done_o !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_done timeout: done_o=%b after %0d cycles, required 1", done_o, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (bus.req !== '0) begin
            errors++; $display("FAIL reset_req: got %h required 0", bus.req);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy_o, done_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned();
        bus.resp.ready = 1'b1;
        start_xfer(32'h1000, 32'd256);
        checks++;
        if (busy_o !== 1'b1 || bus.req.valid !== 1'b0) begin
            errors++; $display("FAIL aligned_calc: busy=%b valid=%b required 1 0", busy_o, bus.req.valid);
        end
        step();
        checks++;
        if (bus.req.valid !== 1'b1 || bus.req.addr !== 32'h1000) begin
            errors++; $display("FAIL aligned_req: valid=%b addr=%h required 1 00001000", bus.req.valid, bus.req.addr);
        end
        checks++;
        if (bus.req.alen !== 8'd3 || bus.req.size !== 3'd6 || bus.req.strb !== {64{1'b1}}) begin
            errors++; $display("FAIL aligned_fields: alen=%0d size=%0d strb=%h required 3 6 all-ones",
                               bus.req.alen, bus.req.size, bus.req.strb);
        end
        step();
        checks++;
        if (done_o !== 1'b1 || bus.req.valid !== 1'b0) begin
            errors++; $display("FAIL aligned_done: done=%b valid=%b required 1 0", done_o, bus.req.valid);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL aligned_idle: done=%b busy=%b required 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] ea[4] = '{32'h1003, 32'h1004, 32'h1008, 32'h100A};
        logic [2:0]  es[4] = '{3'd0, 3'd2, 3'd1, 3'd0};
        logic [63:0] eb[4] = '{64'h8, 64'hF0, 64'h300, 64'h400};
        int d0;
        hs_q.delete();
        d0 = done_cnt;
        start_xfer(32'h1003, 32'd8);
        wait_done(40);
        step();
        checks++;
        if (hs_q.size() != 4) begin
            errors++; $display("FAIL unaligned_count: got %0d requests required 4", hs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (hs_q[i].addr !== ea[i] || hs_q[i].size !== es[i] ||
                    hs_q[i].strb !== eb[i] || hs_q[i].alen !== 8'd0) begin
                    errors++;
                    $display("FAIL unaligned_req%0d: addr=%h size=%0d strb=%h alen=%0d required %h %0d %h 0",
                             i, hs_q[i].addr, hs_q[i].size, hs_q[i].strb, hs_q[i].alen, ea[i], es[i], eb[i]);
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL unaligned_done_cnt: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_4k_crossing();
        hs_q.delete(); hs4_q.delete();
        start_xfer(32'h0FC0, 32'd128);
        wait_done(40);
        repeat (4) step();
        checks++;
        if (hs_q.size() != 2) begin
            errors++; $display("FAIL page_count: got %0d requests required 2", hs_q.size());
        end else begin
            checks++;
            if (hs_q[0].addr !== 32'h0FC0 || hs_q[0].alen !== 8'd0 || hs_q[0].size !== 3'd6) begin
                errors++; $display("FAIL page_req0: addr=%h alen=%0d size=%0d required 00000fc0 0 6",
                                   hs_q[0].addr, hs_q[0].alen, hs_q[0].size);
            end
            checks++;
            if (hs_q[1].addr !== 32'h1000 || hs_q[1].alen !== 8'd0 || hs_q[1].strb !== {64{1'b1}}) begin
                errors++; $display("FAIL page_req1: addr=%h alen=%0d strb=%h required 00001000 0 all-ones",
                                   hs_q[1].addr, hs_q[1].alen, hs_q[1].strb);
            end
        end
        hs_q.delete(); hs4_q.delete();
        start_xfer(32'h0, 32'd512);
        wait_done(40);
        repeat (6) step();
        checks++;
        if (hs_q.size() != 1 || hs_q[0].alen !== 8'd7) begin
            errors++; $display("FAIL burst256_req: count=%0d required 1 with alen 7", hs_q.size());
        end
        checks++;
        if (hs4_q.size() != 2) begin
            errors++; $display("FAIL burst4_count: got %0d requests required 2", hs4_q.size());
        end else begin
            checks++;
            if (hs4_q[0].addr !== 32'h0 || hs4_q[0].alen !== 8'd3 ||
                hs4_q[1].addr !== 32'h100 || hs4_q[1].alen !== 8'd3) begin
                errors++; $display("FAIL burst4_reqs: %h/%0d %h/%0d required 00000000/3 00000100/3",
                                   hs4_q[0].addr, hs4_q[0].alen, hs4_q[1].addr, hs4_q[1].alen);
            end
        end
    endtask

    task automatic test_backpressure();
        int d0;
        bus.resp.ready = 1'b0;
        hs_q.delete();
        d0 = done_cnt;
        start_xfer(32'h2000, 32'd64);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.req.valid !== 1'b1 || bus.req.addr !== 32'h2000 || bus.req.alen !== 8'd0 ||
                bus.req.size !== 3'd6 || bus.req.strb !== {64{1'b1}}) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b addr=%h alen=%0d size=%0d required 1 00002000 0 6",
                                   i, bus.req.valid, bus.req.addr, bus.req.alen, bus.req.size);
            end
        end
        step();
        bus.resp.ready = 1'b1;
        step();
        checks++;
        if (done_o !== 1'b1 || bus.req.valid !== 1'b0 || hs_q.size() != 1) begin
            errors++; $display("FAIL bp_release: done=%b valid=%b hs=%0d required 1 0 1",
                               done_o, bus.req.valid, hs_q.size());
        end
        step();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int d0;
        bus.resp.ready = 1'b0;
        d0 = done_cnt;
        start_xfer(32'h3000, 32'd128);
        step();
        checks++;
        if (bus.req.valid !== 1'b1) begin
            errors++; $display("FAIL abort_pre: valid=%b required 1", bus.req.valid);
        end
        clear_dma = 1'b1;
        step();
        clear_dma = 1'b0;
        checks++;
        if (bus.req.valid !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL abort_state: valid=%b busy=%b done=%b required 0 0 0",
                               bus.req.valid, busy_o, done_o);
        end
        step();
        checks++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        bus.resp.ready = 1'b1;
        hs_q.delete();
        start_xfer(32'h4000, 32'd64);
        wait_done(20);
        step();
        checks++;
        if (hs_q.size() != 1 || hs_q[0].addr !== 32'h4000) begin
            errors++; $display("FAIL abort_restart: count=%0d required 1 request at 00004000", hs_q.size());
        end
    endtask

    task automatic test_inactive();
        dma_active = 1'b0;
        start_xfer(32'h7000, 32'd64);
        step();
        checks++;
        if (busy_o !== 1'b0 || bus.req.valid !== 1'b0) begin
            errors++; $display("FAIL inactive_start: busy=%b valid=%b required 0 0", busy_o, bus.req.valid);
        end
        dma_active = 1'b1;
    endtask

    task automatic test_zero_length();
        start_xfer(32'h5000, 32'd0);
        checks++;
        if (done_o !== 1'b1 || bus.req.valid !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b valid=%b required 1 0", done_o, bus.req.valid);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || bus.req.valid !== 1'b0) begin
            errors++; $display("FAIL zero_idle: done=%b busy=%b valid=%b required 0 0 0",
                               done_o, busy_o, bus.req.valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.resp.ready = 1'b0;
        start_xfer(32'h6000, 32'd256);
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.req !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid: req=%h busy=%b done=%b required all 0", bus.req, busy_o, done_o);
        end
        rst = 1'b0;
        bus.resp.ready = 1'b1;
        step();
    endtask

    initial begin
        bus.resp.ready  = 1'b1;
        bus4.resp.ready = 1'b1;
        test_reset();
        test_aligned();
        test_unaligned();
        test_4k_crossing();
        test_backpressure();
        test_abort();
        test_inactive();
        test_zero_length();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
